picoctrl_prog_mem: RTL and testbench

//  Writable, parametrised program memory for the PicoCtrl sequencer; replaces the fixed 32-word instruction ROM.

---
 rtl/picoctrl_prog_mem.sv | 203 ++++++++++++++++++++
 tb/tb_picoctrl_prog_mem.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/picoctrl_prog_mem.sv
`default_nettype none
// ============================================================================
// Module   : picoctrl_prog_mem
// Purpose  : Writable PicoCtrl program memory with a self-clear after reset,
//            a byte-serial download port and a 1-cycle registered fetch port.
// Revision : 1.0 - initial release
// ============================================================================
module picoctrl_prog_mem #(
    parameter int                ADDR_W   = 5,
    parameter int                DATA_W   = 16,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_valid,
    input  logic              load_start,
    input  logic              load_byte_valid,
    input  logic [7:0]        load_byte,
    input  logic              load_end,
    output logic              load_ready,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_err
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int BYTES = DATA_W / 8;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [CNT_W-1:0]  c_LAST_BYTE = CNT_W'(BYTES - 1);
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = {ADDR_W{1'b1}};

    localparam logic [1:0] c_S_CLEAR = 2'd0;
    localparam logic [1:0] c_S_IDLE  = 2'd1;
    localparam logic [1:0] c_S_LOAD  = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0]  r_byte_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_load_done;
    logic              r_load_err;
    logic [DATA_W-1:0] r_fetch_data;
    logic              r_fetch_valid;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_accept;
    logic              w_word_done;
    logic              w_auto_end;
    logic              w_load_fin;
    logic              w_partial;
    logic [DATA_W-1:0] w_word;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_waddr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic              w_load_ready;
    logic              w_load_busy;

    // ------------------------------------------------------------------
    // FSM: state register / next-state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_CLEAR: if (r_clr_ptr == c_LAST_ADDR) w_state_nxt = c_S_IDLE;
            c_S_IDLE:  if (load_start)               w_state_nxt = c_S_LOAD;
            c_S_LOAD:  if (w_load_fin)               w_state_nxt = c_S_IDLE;
            default:                                 w_state_nxt = c_S_CLEAR;
        endcase
    end

    always_comb begin
        w_load_ready = 1'b0;
        w_load_busy  = 1'b1;
        case (r_state)
            c_S_IDLE: w_load_busy  = 1'b0;
            c_S_LOAD: w_load_ready = 1'b1;
            default:  ;
        endcase
    end

    // ------------------------------------------------------------------
    // Download control
    // ------------------------------------------------------------------
    assign w_accept    = load_byte_valid && (r_state == c_S_LOAD);
    assign w_word_done = w_accept && (r_byte_cnt == c_LAST_BYTE);
    assign w_auto_end  = w_word_done && (r_wr_ptr == c_LAST_ADDR);
    assign w_load_fin  = (r_state == c_S_LOAD) && (load_end || w_auto_end);
    assign w_cnt_nxt   = !w_accept   ? r_byte_cnt :
                         w_word_done ? '0         : r_byte_cnt + 1'b1;
    // A byte arriving with load_end is counted before the partial check
    assign w_partial   = load_end && (w_cnt_nxt != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_clr_ptr   <= '0;
            r_wr_ptr    <= '0;
            r_byte_cnt  <= '0;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_load_done <= w_load_fin;
            if (r_state == c_S_CLEAR) begin
                r_clr_ptr <= r_clr_ptr + 1'b1;
            end
            if ((r_state == c_S_IDLE) && load_start) begin
                r_wr_ptr   <= '0;
                r_byte_cnt <= '0;
                r_load_err <= 1'b0;
            end else if (r_state == c_S_LOAD) begin
                r_byte_cnt <= w_load_fin ? '0 : w_cnt_nxt;
                if (w_word_done && !w_auto_end) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_partial) begin
                    r_load_err <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Byte assembler, MSB-first
    // ------------------------------------------------------------------
    generate
        if (BYTES == 1) begin : g_asm_none
            assign w_word = load_byte;
        end else if (BYTES == 2) begin : g_asm_one
            logic [7:0] r_asm;
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_asm <= '0;
                end else if (w_accept) begin
                    r_asm <= load_byte;
                end
            end
            assign w_word = {r_asm, load_byte};
        end else begin : g_asm_multi
            logic [DATA_W-9:0] r_asm;
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_asm <= '0;
                end else if (w_accept) begin
                    r_asm <= {r_asm[DATA_W-17:0], load_byte};
                end
            end
            assign w_word = {r_asm, load_byte};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Memory array: written by CLEAR or by completed download words only
    // ------------------------------------------------------------------
    assign w_mem_we    = (r_state == c_S_CLEAR) || w_word_done;
    assign w_mem_waddr = (r_state == c_S_CLEAR) ? r_clr_ptr : r_wr_ptr;
    assign w_mem_wdata = (r_state == c_S_CLEAR) ? NOP_WORD  : w_word;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    // Fetch is only served from IDLE, so it never collides with a write
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_data  <= NOP_WORD;
            r_fetch_valid <= 1'b0;
        end else if (fetch_en) begin
            if (r_state == c_S_IDLE) begin
                r_fetch_data  <= r_mem[fetch_addr];
                r_fetch_valid <= 1'b1;
            end else begin
                r_fetch_data  <= NOP_WORD;
                r_fetch_valid <= 1'b0;
            end
        end else begin
            r_fetch_valid <= 1'b0;
        end
    end

    assign fetch_data  = r_fetch_data;
    assign fetch_valid = r_fetch_valid;
    assign load_ready  = w_load_ready;
    assign load_busy   = w_load_busy;
    assign load_done   = r_load_done;
    assign load_err    = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_picoctrl_prog_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_picoctrl_prog_mem
// Purpose  : Directed self-checking bench for picoctrl_prog_mem.
// Revision : 1.0 - initial release
// ============================================================================
module tb_picoctrl_prog_mem;

    localparam int          c_ADDR_W = 5;
    localparam int          c_DATA_W = 16;
    localparam logic [15:0] c_NOP    = 16'hC0DE;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        fetch_en = 1'b0;
    logic [4:0]  fetch_addr = '0;
    logic [15:0] fetch_data;
    logic        fetch_valid;
    logic        load_start = 1'b0;
    logic        load_byte_valid = 1'b0;
    logic [7:0]  load_byte = '0;
    logic        load_end = 1'b0;
    logic        load_ready;
    logic        load_busy;
    logic        load_done;
    logic        load_err;

    int total = 0;
    int bad   = 0;

    picoctrl_prog_mem #(
        .ADDR_W   (c_ADDR_W),
        .DATA_W   (c_DATA_W),
        .NOP_WORD (c_NOP)
    ) u_dut (
        .clk             (clk),
        .reset           (reset),
        .fetch_en        (fetch_en),
        .fetch_addr      (fetch_addr),
        .fetch_data      (fetch_data),
        .fetch_valid     (fetch_valid),
        .load_start      (load_start),
        .load_byte_valid (load_byte_valid),
        .load_byte       (load_byte),
        .load_end        (load_end),
        .load_ready      (load_ready),
        .load_busy       (load_busy),
        .load_done       (load_done),
        .load_err        (load_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset_and_clear(input string tag, input bit poke_start);
        int cnt;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk({tag, "_busy0"}, 32'(load_busy), 32'd1);
        chk({tag, "_valid0"}, 32'(fetch_valid), 32'd0);
        chk({tag, "_data0"}, 32'(fetch_data), 32'(c_NOP));
        chk({tag, "_done0"}, 32'(load_done), 32'd0);
        chk({tag, "_err0"}, 32'(load_err), 32'd0);
        cnt = 0;
        while (load_busy && cnt < 200) begin
            load_start = poke_start && (cnt == 0);
            tick();
            cnt++;
        end
        load_start = 1'b0;
        chk({tag, "_clear_cycles"}, 32'(cnt), 32'd32);
        chk({tag, "_ready_after_clear"}, 32'(load_ready), 32'd0);
    endtask

    task automatic fetch(input string tag, input logic [4:0] a,
                         input logic [15:0] exp_d, input logic exp_v);
        fetch_en   = 1'b1;
        fetch_addr = a;
        tick();
        fetch_en = 1'b0;
        chk({tag, "_valid"}, 32'(fetch_valid), 32'(exp_v));
        chk({tag, "_data"}, 32'(fetch_data), 32'(exp_d));
    endtask

    task automatic start_load(input string tag);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk({tag, "_ready"}, 32'(load_ready), 32'd1);
        chk({tag, "_err_clr"}, 32'(load_err), 32'd0);
    endtask

    task automatic send(input logic [7:0] b, input logic with_end);
        load_byte_valid = 1'b1;
        load_byte       = b;
        load_end        = with_end;
        tick();
        load_byte_valid = 1'b0;
        load_end        = 1'b0;
    endtask

    task automatic end_load(input string tag, input logic exp_err);
        load_end = 1'b1;
        tick();
        load_end = 1'b0;
        chk({tag, "_done"}, 32'(load_done), 32'd1);
        chk({tag, "_err"}, 32'(load_err), 32'(exp_err));
        tick();
        chk({tag, "_done_pulse"}, 32'(load_done), 32'd0);
        chk({tag, "_ready_low"}, 32'(load_ready), 32'd0);
    endtask

    function automatic logic [7:0] t4_byte(input int i);
        return 8'(i * 7 + 3);
    endfunction

    initial begin
        // T1: reset, 32-cycle clear (load_start ignored), fetch top word
        do_reset_and_clear("t1", 1'b1);
        fetch("t1_f31", 5'h1F, c_NOP, 1'b1);
        tick();
        chk("t1_valid_pulse", 32'(fetch_valid), 32'd0);
        chk("t1_data_hold", 32'(fetch_data), 32'(c_NOP));

        // T2: two full words
        start_load("t2");
        send(8'h12, 1'b0);
        send(8'h34, 1'b0);
        send(8'h56, 1'b0);
        send(8'h78, 1'b0);
        end_load("t2", 1'b0);
        fetch("t2_f1", 5'd1, 16'h5678, 1'b1);
        fetch("t2_f0", 5'd0, 16'h1234, 1'b1);

        // T3: partial word dropped, mem[1] keeps its earlier contents
        start_load("t3");
        send(8'hAB, 1'b0);
        send(8'hCD, 1'b0);
        send(8'hEF, 1'b0);
        end_load("t3", 1'b1);
        fetch("t3_f0", 5'd0, 16'hABCD, 1'b1);
        fetch("t3_f1", 5'd1, 16'h5678, 1'b1);
        chk("t3_err_sticky", 32'(load_err), 32'd1);

        // T5: load_end coincides with the last byte of a word
        start_load("t5");
        send(8'h9A, 1'b0);
        send(8'hBC, 1'b0);
        send(8'hDE, 1'b0);
        send(8'hF0, 1'b1);
        chk("t5_done", 32'(load_done), 32'd1);
        chk("t5_err", 32'(load_err), 32'd0);
        fetch("t5_f0", 5'd0, 16'h9ABC, 1'b1);
        fetch("t5_f1", 5'd1, 16'hDEF0, 1'b1);

        // T4: full 64-byte image, auto-end on word 31, 65th byte ignored
        start_load("t4");
        for (int i = 0; i < 63; i++) begin
            send(t4_byte(i), 1'b0);
        end
        chk("t4_not_done_63", 32'(load_done), 32'd0);
        chk("t4_ready_63", 32'(load_ready), 32'd1);
        send(t4_byte(63), 1'b0);
        chk("t4_done_64", 32'(load_done), 32'd1);
        chk("t4_ready_64", 32'(load_ready), 32'd0);
        chk("t4_err", 32'(load_err), 32'd0);
        send(8'hFF, 1'b0);
        chk("t4_done_65", 32'(load_done), 32'd0);
        fetch("t4_f31", 5'd31, {t4_byte(62), t4_byte(63)}, 1'b1);
        fetch("t4_f0", 5'd0, {t4_byte(0), t4_byte(1)}, 1'b1);
        fetch("t4_f17", 5'd17, {t4_byte(34), t4_byte(35)}, 1'b1);

        // T6: fetch during LOAD, then reset mid-download
        start_load("t6");
        fetch("t6_fload", 5'd17, c_NOP, 1'b0);
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        do_reset_and_clear("t6", 1'b0);
        fetch("t6_f0", 5'd0, c_NOP, 1'b1);
        fetch("t6_f1", 5'd1, c_NOP, 1'b1);
        fetch("t6_f31", 5'd31, c_NOP, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
